conv_window_feeder: RTL and testbench

CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

---
 rtl/conv_window_feeder.sv | 92 +++++++++
 tb/tb_conv_window_feeder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: line-buffers a raster frame and feeds Size x Size windows to a ConvUnit, one result per window.
module conv_window_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int Size       = 5,
  parameter int ImgWidth   = 14,
  parameter int ImgHeight  = 14
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             pix_in,
  input  logic                              pix_valid,
  output logic                              pix_ready,
  output logic [Size*Size*DATA_WIDTH-1:0]   window,
  output logic                              conv_reset,
  input  logic                              conv_done,
  input  logic [DATA_WIDTH-1:0]             conv_result,
  output logic [DATA_WIDTH-1:0]             out_result,
  output logic                              out_valid,
  output logic                              frame_done
);
  localparam int CW = ImgWidth > 1 ? $clog2(ImgWidth) : 1;
  localparam int RW = ImgHeight > 1 ? $clog2(ImgHeight) : 1;
  localparam int SW = Size > 1 ? $clog2(Size) : 1;
  typedef enum logic [2:0] {FILL, START, WAIT, EMIT, LOAD} state_t;
  state_t r_state, w_next;
  logic [DATA_WIDTH-1:0] r_buf [Size][ImgWidth];
  logic [Size*Size*DATA_WIDTH-1:0] r_window, w_win;
  logic [DATA_WIDTH-1:0] r_result;
  logic [CW-1:0] r_col, r_wcol;
  logic [RW-1:0] r_orow;
  logic [SW-1:0] r_wrow, w_dst_row;
  logic w_take, w_row_end, w_col_end, w_row_last, w_shift;
  assign pix_ready  = r_state == FILL || r_state == LOAD;
  assign conv_reset = r_state != WAIT;
  assign out_valid  = r_state == EMIT;
  assign w_take     = pix_valid && pix_ready;
  assign w_row_end  = r_wcol == CW'(ImgWidth - 1);
  assign w_col_end  = r_col == CW'(ImgWidth - Size);
  assign w_row_last = r_orow == RW'(ImgHeight - Size);
  assign w_shift    = out_valid && w_col_end && !w_row_last;
  assign frame_done = out_valid && w_col_end && w_row_last;
  assign w_dst_row  = r_state == LOAD ? SW'(Size - 1) : r_wrow;
  assign window     = r_window;
  assign out_result = r_result;
  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:    w_next = w_take && w_row_end && r_wrow == SW'(Size - 1) ? START : FILL;
      START:   w_next = WAIT;
      WAIT:    w_next = conv_done ? EMIT : WAIT;
      EMIT:    w_next = !w_col_end ? START : !w_row_last ? LOAD : FILL;
      LOAD:    w_next = w_take && w_row_end ? START : LOAD;
      default: w_next = FILL;
    endcase
  end
  // Top-left of the window lands in the MSBs, bottom-right in the LSBs.
  always_comb begin
    w_win = '0;
    for (int r = 0; r < Size; r++)
      for (int c = 0; c < Size; c++)
        w_win[(Size*Size - r*Size - c)*DATA_WIDTH-1 -: DATA_WIDTH] = r_buf[SW'(r)][r_col + CW'(c)];
  end
  // Buffer contents need no reset: every frame refills all rows before use.
  always_ff @(posedge clk) begin
    if (w_take) r_buf[w_dst_row][r_wcol] <= pix_in;
    if (w_shift)
      for (int r = 0; r < Size - 1; r++) r_buf[SW'(r)] <= r_buf[SW'(r + 1)];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FILL;
      r_col    <= '0;
      r_orow   <= '0;
      r_wcol   <= '0;
      r_wrow   <= '0;
      r_window <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) r_wcol <= w_row_end ? '0 : r_wcol + 1'b1;
      if (w_take && r_state == FILL && w_row_end) r_wrow <= r_wrow == SW'(Size - 1) ? '0 : r_wrow + 1'b1;
      if (r_state == START) r_window <= w_win;
      if (r_state == WAIT && conv_done) r_result <= conv_result;
      if (out_valid) r_col <= w_col_end ? '0 : r_col + 1'b1;
      if (w_shift) r_orow <= r_orow + 1'b1;
      if (frame_done) begin
        r_orow <= '0;
        r_wrow <= '0;
      end
    end
  end
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: directed 6x6 frames against a stub ConvUnit, checking windows, results and handshakes.
module tb_conv_window_feeder;
  localparam int DW = 16;
  localparam int WB = 25 * DW;
  logic clk = 0, reset = 0, pix_valid = 0, pix_ready, conv_reset, conv_done, out_valid, frame_done;
  logic [DW-1:0] pix_in = '0, conv_result, out_result;
  logic [WB-1:0] window;
  logic s_done = 0, force_done = 0;
  logic [DW-1:0] s_res = '0;
  int s_cnt = 0;
  int checks = 0, errors = 0;
  logic [DW-1:0] res_q[$];
  logic [WB-1:0] win_q[$];
  int fd_res[$];
  int fd_cnt = 0, acc_cnt = 0, fall_cnt = 0, rdy_after_fd = 0;
  bit chk_next = 0, prev_cr = 1;
  always #5 clk = ~clk;
  conv_window_feeder #(.DATA_WIDTH(16), .Size(5), .ImgWidth(6), .ImgHeight(6)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .window(window), .conv_reset(conv_reset), .conv_done(conv_done), .conv_result(conv_result),
    .out_result(out_result), .out_valid(out_valid), .frame_done(frame_done));
  function automatic logic [DW-1:0] stub_calc(input logic [WB-1:0] w);
    logic [DW-1:0] s;
    bit ones;
    s = '0;
    ones = 1;
    for (int k = 0; k < 25; k++) begin
      s = s + w[k*DW +: DW];
      if (w[k*DW +: DW] !== 16'h3C00) ones = 0;
    end
    return ones ? 16'h4E40 : s;
  endfunction
  function automatic logic [DW-1:0] el(input logic [WB-1:0] w, input int r, input int c);
    return w[(25 - 5*r - c)*DW-1 -: DW];
  endfunction
  always @(posedge clk) begin
    if (conv_reset) begin
      s_cnt  <= 0;
      s_done <= 0;
    end else begin
      s_cnt  <= s_cnt + 1;
      s_done <= s_cnt == 2;
      s_res  <= stub_calc(window);
    end
  end
  assign conv_done   = s_done | force_done;
  assign conv_result = s_res;
  always @(negedge clk) begin
    if (chk_next && pix_ready) rdy_after_fd++;
    chk_next = 0;
    if (out_valid) res_q.push_back(out_result);
    if (frame_done) begin
      fd_cnt++;
      fd_res.push_back(res_q.size());
      chk_next = 1;
    end
    if (pix_valid && pix_ready && !reset) acc_cnt++;
    if (!conv_reset && prev_cr) begin
      fall_cnt++;
      win_q.push_back(window);
    end
    prev_cr = conv_reset;
  end
  task automatic clear();
    res_q.delete();
    win_q.delete();
    fd_res.delete();
    fd_cnt = 0;
    acc_cnt = 0;
    fall_cnt = 0;
    rdy_after_fd = 0;
  endtask
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1;
    pix_valid = 0;
    repeat (n) @(posedge clk);
    #1 reset = 0;
  endtask
  task automatic send(input int n, input bit ones, input bit gap, input int stop);
    int idx = 0, b = 0;
    bit tog = 0;
    while (idx < n && b < 3000 && !(stop > 0 && fall_cnt >= stop)) begin
      @(posedge clk); #1;
      tog = !tog;
      pix_valid = gap ? tog : 1'b1;
      pix_in = ones ? 16'h3C00 : 16'(idx % 36);
      if (pix_valid && pix_ready) idx++;
      b++;
    end
    @(posedge clk); #1 pix_valid = 0;
    if (b >= 3000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout accepted=%0d required=%0d", idx, n);
    end
  endtask
  task automatic wait_results(input int n);
    int b = 0;
    while (res_q.size() < n && b < 400) begin
      @(negedge clk);
      b++;
    end
    repeat (20) @(negedge clk);
  endtask
  task automatic check_results(input string tag, input int n, input logic [DW-1:0] e0, e1, e2, e3);
    logic [DW-1:0] exp_v [4];
    exp_v = '{e0, e1, e2, e3};
    checks++;
    if (res_q.size() !== n) begin
      errors++;
      $display("FAIL %s_count got=%0d exp=%0d", tag, res_q.size(), n);
    end
    for (int i = 0; i < n && i < res_q.size(); i++) begin
      checks++;
      if (res_q[i] !== exp_v[i % 4]) begin
        errors++;
        $display("FAIL %s_result%0d got=%h exp=%h", tag, i, res_q[i], exp_v[i % 4]);
      end
    end
  endtask
  task automatic test_reset();
    do_reset(2);
    @(negedge clk);
    checks += 6;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL rst_pix_ready got=%b exp=1", pix_ready); end
    if (conv_reset !== 1'b1) begin errors++; $display("FAIL rst_conv_reset got=%b exp=1", conv_reset); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
    if (out_result !== 16'h0) begin errors++; $display("FAIL rst_out_result got=%h exp=0", out_result); end
    if (window !== '0) begin errors++; $display("FAIL rst_window got=%h exp=0", window); end
  endtask
  task automatic test_frame_ones(input string tag, input bit gap);
    clear();
    send(36, 1, gap, 0);
    wait_results(4);
    check_results(tag, 4, 16'h4E40, 16'h4E40, 16'h4E40, 16'h4E40);
    checks += 3;
    if (fd_cnt !== 1) begin errors++; $display("FAIL %s_frame_done got=%0d exp=1", tag, fd_cnt); end
    if (fd_res.size() != 1 || fd_res[0] !== 4) begin errors++; $display("FAIL %s_fd_with_4th got=%0d exp=4", tag, fd_res.size() ? fd_res[0] : -1); end
    if (acc_cnt !== 36) begin errors++; $display("FAIL %s_accepted got=%0d exp=36", tag, acc_cnt); end
  endtask
  task automatic test_raster_windows();
    clear();
    send(36, 0, 0, 0);
    wait_results(4);
    checks += 5;
    if (win_q.size() !== 4) begin
      errors++;
      $display("FAIL win_count got=%0d exp=4", win_q.size());
    end else begin
      if (el(win_q[0], 0, 0) !== 16'd0) begin errors++; $display("FAIL win0_00 got=%0d exp=0", el(win_q[0], 0, 0)); end
      if (el(win_q[0], 4, 4) !== 16'd28) begin errors++; $display("FAIL win0_44 got=%0d exp=28", el(win_q[0], 4, 4)); end
      if (el(win_q[1], 0, 0) !== 16'd1) begin errors++; $display("FAIL win1_00 got=%0d exp=1", el(win_q[1], 0, 0)); end
      if (el(win_q[2], 0, 0) !== 16'd6) begin errors++; $display("FAIL win2_00 got=%0d exp=6", el(win_q[2], 0, 0)); end
    end
    check_results("raster", 4, 16'd350, 16'd375, 16'd500, 16'd525);
  endtask
  task automatic test_abort();
    clear();
    send(36, 0, 0, 2);
    do_reset(1);
    @(negedge clk);
    checks += 3;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL abort_pix_ready got=%b exp=1", pix_ready); end
    if (conv_reset !== 1'b1) begin errors++; $display("FAIL abort_conv_reset got=%b exp=1", conv_reset); end
    if (out_result !== 16'h0) begin errors++; $display("FAIL abort_out_result got=%h exp=0", out_result); end
    force_done = 1;
    repeat (3) @(negedge clk);
    force_done = 0;
    repeat (5) @(negedge clk);
    checks += 2;
    if (res_q.size() !== 1) begin errors++; $display("FAIL abort_results got=%0d exp=1", res_q.size()); end
    if (fd_cnt !== 0) begin errors++; $display("FAIL abort_frame_done got=%0d exp=0", fd_cnt); end
    clear();
    send(36, 0, 0, 0);
    wait_results(4);
    check_results("after_abort", 4, 16'd350, 16'd375, 16'd500, 16'd525);
  endtask
  task automatic test_back_to_back();
    clear();
    send(72, 0, 0, 0);
    wait_results(8);
    check_results("b2b", 8, 16'd350, 16'd375, 16'd500, 16'd525);
    checks += 2;
    if (fd_cnt !== 2) begin errors++; $display("FAIL b2b_frame_done got=%0d exp=2", fd_cnt); end
    if (rdy_after_fd !== 2) begin errors++; $display("FAIL b2b_ready_after_fd got=%0d exp=2", rdy_after_fd); end
  endtask
  initial begin
    test_reset();
    test_frame_ones("ones", 0);
    test_raster_windows();
    test_frame_ones("gaps", 1);
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
